icache_responder: RTL and testbench
===================================

ICACHE_RESPONDER -- requirements
Module: icache_responder

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped cache lines (power of 2, >=2).
REQ-002 Parameter: WORDS, default 4, 32-bit words per line (power of 2, >=2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only at posedge clk.
REQ-005 icache_addr  input  32  byte address of the instruction fetch; bits [1:0] ignored.
REQ-006 icache_re  input  1  fetch request, sampled at posedge clk.
REQ-007 icache_dout  output  32  instruction word for the previously accepted fetch.
REQ-008 stall  output  1  high while icache_dout is not yet valid for the accepted fetch.
REQ-009 mem_req_valid  output  1  line refill request to backing memory.
REQ-010 mem_req_addr  output  32  line-aligned byte address of the refill (low log2(WORDS)+2 bits zero).
REQ-011 mem_req_ready  input  1  memory accepts the request when mem_req_valid and mem_req_ready are both high at posedge.
REQ-012 mem_resp_valid  input  1  one refill beat present on mem_resp_data.
REQ-013 mem_resp_data  input  32  refill word; beats arrive in ascending word order, exactly WORDS beats per request.

Function
REQ-014 Address split: word offset = addr[log2(WORDS)+1:2], index = next log2(LINES) bits, tag = remaining upper bits (24 bits at defaults).
REQ-015 Storage: per line one valid bit, one tag, WORDS data words; registers, no SRAM macro.
REQ-016 States: LOOKUP, REQ, FILL, RESP.
REQ-017 Fetch acceptance: at posedge with icache_re=1 and stall=0, the block SHALL latch icache_addr; with icache_re=0 it SHALL hold the previous latched address and icache_dout.
REQ-018 LOOKUP hit (valid and tag match for latched address): stall=0, icache_dout = stored word in the same cycle, i.e. 1-cycle latency after acceptance.
REQ-019 LOOKUP miss: stall=1 combinationally in that cycle; next state REQ.
REQ-020 REQ: mem_req_valid=1, mem_req_addr = line base of latched address, both held stable until handshake; on handshake go to FILL with beat counter = 0.
REQ-021 FILL: each mem_resp_valid beat writes mem_resp_data into word[beat] of the indexed line and increments the counter; mem_resp_valid=0 cycles stall with no state change.
REQ-022 On the final beat (counter = WORDS-1) the line tag is written and valid set; next state RESP.
REQ-023 RESP: stall=0, icache_dout = requested word from the filled line; next state LOOKUP; icache_re/icache_addr sampled this cycle as a new fetch.
REQ-024 stall SHALL be 1 in every REQ and FILL cycle and 0 in RESP and on LOOKUP hit.
REQ-025 While stall=1, icache_addr/icache_re changes SHALL be ignored; the latched address is not replaced.
REQ-026 Refill replaces any prior line at the index (valid or not); no write port from the CPU side.
REQ-027 mem_resp_valid outside FILL SHALL be ignored.
REQ-028 LOOKUP with no fetch ever accepted since reset: stall=0, icache_dout = 0.

Reset
REQ-029 reset=0 at posedge: state LOOKUP, all valid bits 0, latched-address valid flag 0, beat counter 0, mem_req_valid=0, stall=0, icache_dout=0 from the next cycle.
REQ-030 Reset asserted during REQ or FILL SHALL abort the refill; the partially filled line remains invalid; subsequent memory beats are ignored.
REQ-031 Tag/data contents need not be reset.

Verification
REQ-032 After reset, fetch 0x0000_0040, memory ready immediately, beats 0xA0..0xA3 one per cycle -> mem_req_addr=0x40, stall high 1 (LOOKUP) + 1 (REQ) + 4 (FILL) cycles, RESP dout=0xA0.
REQ-033 Then fetch 0x44, 0x48, 0x4C back-to-back -> stall=0 each, dout 0xA1, 0xA2, 0xA3 one cycle after each acceptance, no mem_req_valid.
REQ-034 Fetch 0x0000_0440 (same index, different tag) -> miss, mem_req_addr=0x440; afterwards fetch 0x40 -> miss again (eviction).
REQ-035 mem_req_ready held low 5 cycles, mem_resp_valid gapped (beat, idle, beat, ...) -> mem_req_addr stable, stall held, correct word returned, icache_addr toggling during stall ignored.
REQ-036 reset pulsed after 2 refill beats -> stall=0, mem_req_valid=0 next cycle; refetch of same address misses and re-requests.
REQ-037 icache_re=0 for 3 cycles after a hit -> dout and stall unchanged, no memory traffic.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, register-based instruction cache with a single-outstanding line refill.
// A fetch is latched on acceptance and answered from the line array one cycle later, or after a refill.
module icache_responder #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] icache_addr,
   input  logic        icache_re,
   output logic [31:0] icache_dout,
   output logic        stall,
   output logic        mem_req_valid,
   output logic [31:0] mem_req_addr,
   input  logic        mem_req_ready,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);
   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 32 - OFF_W - IDX_W - 2;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

   typedef enum logic [1:0] {LOOKUP, REQ, FILL, RESP} state_t;

   state_t                              state, state_nxt;
   logic [31:2]                         addr_q;
   logic                                addr_vld;
   logic [OFF_W-1:0]                    beat_cnt;
   logic [LINES-1:0]                    line_vld;
   logic [LINES-1:0][TAG_W-1:0]         tags;
   logic [LINES-1:0][WORDS-1:0][31:0]   data;

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             hit, accept, beat_we;
   logic             unused_addr_lsb;

   assign unused_addr_lsb = ^icache_addr[1:0];

   assign off    = addr_q[OFF_W+1:2];
   assign idx    = addr_q[OFF_W+IDX_W+1:OFF_W+2];
   assign tag    = addr_q[31:OFF_W+IDX_W+2];
   assign hit    = addr_vld && line_vld[idx] && (tags[idx] == tag);
   assign accept = icache_re && !stall;
   // Beats outside FILL (including after an aborting reset) never touch the array.
   assign beat_we = reset && (state == FILL) && mem_resp_valid;

   assign mem_req_addr = {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
   assign icache_dout  = addr_vld ? data[idx][off] : 32'h0;

   always_comb begin
      state_nxt     = state;
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      case (state)
         LOOKUP: begin
            if (addr_vld && !hit) begin
               stall     = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = FILL;
         end
         FILL: begin
            stall = 1'b1;
            if (mem_resp_valid && beat_cnt == LAST_BEAT) state_nxt = RESP;
         end
         RESP: state_nxt = LOOKUP;
         default: state_nxt = LOOKUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= LOOKUP;
         addr_vld <= 1'b0;
         beat_cnt <= '0;
         line_vld <= '0;
      end else begin
         state <= state_nxt;
         if (accept) addr_vld <= 1'b1;
         // Counter wraps to zero on the last beat, so it is ready for the next refill.
         if (beat_we) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == LAST_BEAT) line_vld[idx] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset && accept) addr_q <= icache_addr[31:2];
      if (beat_we) begin
         data[idx][beat_cnt] <= mem_resp_data;
         if (beat_cnt == LAST_BEAT) tags[idx] <= tag;
      end
   end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: refill timing, hits, eviction, backpressure, reset abort.
module tb_icache_responder;
   localparam int LINES = 16;
   localparam int WORDS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] icache_addr;
   logic        icache_re;
   logic [31:0] icache_dout;
   logic        stall;
   logic        mem_req_valid;
   logic [31:0] mem_req_addr;
   logic        mem_req_ready;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;

   int n_chk  = 0;
   int n_fail = 0;

   icache_responder #(.LINES(LINES), .WORDS(WORDS)) dut (
      .clk(clk), .reset(reset),
      .icache_addr(icache_addr), .icache_re(icache_re),
      .icache_dout(icache_dout), .stall(stall),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Entered in the LOOKUP-miss cycle; returns in the RESP cycle.
   task automatic fill(input logic [31:0] base, input logic [31:0] d0,
                       input int rdy_dly, input bit gap);
      chk("miss_stall", {31'b0, stall}, 32'd1);
      chk("miss_noreq", {31'b0, mem_req_valid}, 32'd0);
      mem_req_ready = (rdy_dly == 0);
      tick;
      for (int i = 0; i < rdy_dly; i++) begin
         chk("req_valid_wait", {31'b0, mem_req_valid}, 32'd1);
         chk("req_addr_wait", mem_req_addr, base);
         chk("req_stall_wait", {31'b0, stall}, 32'd1);
         icache_addr = 32'h0000_1230 ^ i;
         icache_re   = i[0];
         tick;
      end
      mem_req_ready = 1'b1;
      chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("req_addr", mem_req_addr, base);
      chk("req_stall", {31'b0, stall}, 32'd1);
      tick;
      mem_req_ready = 1'b0;
      icache_re     = 1'b0;
      for (int i = 0; i < WORDS; i++) begin
         chk("fill_stall", {31'b0, stall}, 32'd1);
         chk("fill_noreq", {31'b0, mem_req_valid}, 32'd0);
         mem_resp_valid = 1'b1;
         mem_resp_data  = d0 + i;
         tick;
         mem_resp_valid = 1'b0;
         if (gap && i < WORDS - 1) begin
            chk("gap_stall", {31'b0, stall}, 32'd1);
            tick;
         end
      end
      icache_re = 1'b0;
      chk("resp_stall", {31'b0, stall}, 32'd0);
   endtask

   task automatic fetch(input logic [31:0] a);
      icache_addr = a;
      icache_re   = 1'b1;
      tick;
      icache_re   = 1'b0;
   endtask

   initial begin
      logic [31:0] hit_exp [3];
      hit_exp = '{32'hA1, 32'hA2, 32'hA3};
      reset = 1'b0; icache_addr = '0; icache_re = 1'b0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      tick; tick;
      reset = 1'b1;
      tick;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_dout", icache_dout, 32'h0);
      chk("rst_req", {31'b0, mem_req_valid}, 32'd0);

      // Cold miss, immediate ready, back-to-back beats
      fetch(32'h40);
      fill(32'h40, 32'hA0, 0, 1'b0);
      chk("resp_dout_a0", icache_dout, 32'hA0);

      // Back-to-back hits on the same line
      for (int i = 0; i < 3; i++) begin
         fetch(32'h44 + 4 * i);
         chk("hit_stall", {31'b0, stall}, 32'd0);
         chk("hit_dout", icache_dout, hit_exp[i]);
         chk("hit_noreq", {31'b0, mem_req_valid}, 32'd0);
      end

      // Idle fetch port holds the last result
      icache_addr = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("idle_dout", icache_dout, 32'hA3);
         chk("idle_stall", {31'b0, stall}, 32'd0);
         chk("idle_noreq", {31'b0, mem_req_valid}, 32'd0);
      end

      // Conflict miss evicts line 4
      fetch(32'h440);
      fill(32'h440, 32'hB0, 0, 1'b0);
      chk("evict_dout_b0", icache_dout, 32'hB0);

      // Evicted line misses again; slow ready, gapped beats, address noise during stall
      fetch(32'h48);
      fill(32'h40, 32'hC0, 5, 1'b1);
      chk("slow_dout_c2", icache_dout, 32'hC2);

      // Reset in the middle of a refill
      fetch(32'h80);
      chk("abort_miss", {31'b0, stall}, 32'd1);
      mem_req_ready = 1'b1;
      tick;
      chk("abort_req_addr", mem_req_addr, 32'h80);
      tick;
      mem_req_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'hF0 + i;
         tick;
      end
      mem_resp_data = 32'hF2;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      mem_resp_data = 32'hF3;
      chk("abort_stall", {31'b0, stall}, 32'd0);
      chk("abort_noreq", {31'b0, mem_req_valid}, 32'd0);
      chk("abort_dout", icache_dout, 32'h0);
      tick;
      mem_resp_valid = 1'b0;
      chk("stray_stall", {31'b0, stall}, 32'd0);
      chk("stray_noreq", {31'b0, mem_req_valid}, 32'd0);

      fetch(32'h80);
      fill(32'h80, 32'hE0, 0, 1'b0);
      chk("refetch_dout_e0", icache_dout, 32'hE0);

      // Reset cleared line 4 too
      fetch(32'h44);
      chk("rst_invalidates", {31'b0, stall}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
